// File: rtl/snd_arb_pkg.sv
// Shared types and default sizing for the sound trigger arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package snd_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_PLAY  = 2'd2,
        S_GAP   = 2'd3
    } sndarb_state_t;

    // Default sizing: eight buttons, 1 ms debounce and 50 us gap at 50 MHz
    localparam int N_REQ_DEF        = 8;
    localparam int DEBOUNCE_CYC_DEF = 50000;
    localparam int GAP_CYC_DEF      = 2500;

endpackage

// File: rtl/snd_trigger_arbiter_btn_debounce.sv
// Synchronise and debounce one raw button, flag rising edges of the debounced level.
// Latency: raw edge to rise pulse is DEBOUNCE_CYC+2 cycles for a clean input.
// Backpressure: none; free-running, rise is a one-cycle pulse.
//
// Ports:
//   clk      system clock (CLK_50M domain)
//   reset_n  asynchronous active-low reset
//   btn_raw  raw button level, asynchronous to clk
//   stable   debounced button level
//   rise     one-cycle pulse on each 0->1 transition of stable
module btn_debounce
    import snd_arb_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             stable_q;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser; sync_q1 may go metastable, only sync_q2 is used.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // The count tracks how many consecutive cycles the synchronised value has
    // disagreed with the accepted level; any agreeing cycle restarts it. The
    // level flips on the DEBOUNCE_CYC-th disagreeing cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
        end else begin
            stable_q <= stable;
            if (sync_q2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                stable <= sync_q2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign rise = stable & ~stable_q;

endmodule

// File: rtl/snd_trigger_arbiter.sv
// Round-robin arbiter sharing one sound generator between N_REQ debounced trigger buttons.
// Latency: button edge to pending DEBOUNCE_CYC+3, pending to play_valid 1, play_done to next play_valid GAP_CYC+2.
// Backpressure: play_valid/play_id held until play_ready; later presses wait in pending, repeats coalesce.
//
// Ports:
//   clk         system clock (CLK_50M domain)
//   reset_n     asynchronous active-low reset; drops play_valid and pending at once
//   btn_raw     raw button levels (joystick OR OSD), asynchronous, 1 = pressed
//   play_valid  request to the sound core is valid
//   play_id     sound index, stable while play_valid is high
//   play_ready  sound core accepts when play_valid && play_ready
//   play_done   one-cycle pulse, current sound finished (honoured only in PLAY)
//   play_abort  one-cycle registered stop pulse (preemption build only, else 0)
//   pending     latched, unserviced requests
//   busy        high in every state except IDLE
//
// Build option: define SNDARB_PREEMPT_EN to let a newly latched request abort the
// sound currently playing (abort pulse, then the normal silent gap).
module snd_trigger_arbiter
    import snd_arb_pkg::*;
#(
    parameter int N_REQ        = N_REQ_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int GAP_CYC      = GAP_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         btn_raw,
    output logic                     play_valid,
    output logic [$clog2(N_REQ)-1:0] play_id,
    input  logic                     play_ready,
    input  logic                     play_done,
    output logic                     play_abort,
    output logic [N_REQ-1:0]         pending,
    output logic                     busy
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    sndarb_state_t    state_q;
    logic [ID_W-1:0]  last_id;
    logic [GAP_W-1:0] gap_cnt;
    logic [N_REQ-1:0] btn_stable;
    logic [N_REQ-1:0] btn_rise;
    logic [N_REQ-1:0] clr_mask;
    logic             handshake;

    // ------------------------------------------------------------------
    // Per-button synchroniser + debounce
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N_REQ; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_btn_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .btn_raw (btn_raw[g]),
            .stable  (btn_stable[g]),
            .rise    (btn_rise[g])
        );
    end

    // Only the edge matters; the held level is not otherwise consumed.
    logic unused_stable;
    assign unused_stable = ^btn_stable;

    // ------------------------------------------------------------------
    // Round-robin pick: first set bit strictly after last, wrapping.
    // Scanning k = 1..N_REQ ends on last itself, so a lone request from
    // the previous winner is still found.
    // ------------------------------------------------------------------
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [ID_W-1:0]  last);
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!found && req[idx]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // ------------------------------------------------------------------
    // Pending request latch. A fresh edge in the handshake cycle of the
    // same id wins over the clear, so that press is not lost.
    // ------------------------------------------------------------------
    assign handshake = (state_q == S_ISSUE) && play_ready;
    assign clr_mask  = handshake ? (N_REQ'(1) << play_id) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | btn_rise;
        end
    end

`ifdef SNDARB_PREEMPT_EN
    // Bits that become pending this cycle (repeat presses of an already
    // pending id do not count as new).
    logic [N_REQ-1:0] new_req;
    logic             abort_q;
    assign new_req    = btn_rise & ~pending;
    assign play_abort = abort_q;
`else
    assign play_abort = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Arbiter FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            play_id <= '0;
            last_id <= ID_W'(N_REQ - 1);
            gap_cnt <= '0;
`ifdef SNDARB_PREEMPT_EN
            abort_q <= 1'b0;
`endif
        end else begin
`ifdef SNDARB_PREEMPT_EN
            abort_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    // play_id is only ever written here, which keeps it
                    // stable for the whole ISSUE/PLAY/GAP sequence.
                    if (|pending) begin
                        state_q <= S_ISSUE;
                        play_id <= rr_pick(pending, last_id);
                    end
                end
                S_ISSUE: begin
                    if (play_ready) begin
                        state_q <= S_PLAY;
                        last_id <= play_id;
                    end
                end
                S_PLAY: begin
                    if (play_done) begin
                        state_q <= S_GAP;
                        gap_cnt <= GAP_W'(GAP_CYC - 1);
                    end
`ifdef SNDARB_PREEMPT_EN
                    // A natural end in the same cycle takes precedence,
                    // so no abort is sent for a sound that already ended.
                    else if (|new_req) begin
                        state_q <= S_GAP;
                        gap_cnt <= GAP_W'(GAP_CYC - 1);
                        abort_q <= 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign play_valid = (state_q == S_ISSUE);
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_snd_trigger_arbiter.sv
// Self-checking bench for snd_trigger_arbiter with shortened debounce and gap.
module tb_snd_trigger_arbiter;

    localparam int N = 8;
    localparam int D = 16;
    localparam int G = 20;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic         play_valid;
    logic [2:0]   play_id;
    logic         play_ready = 1'b0;
    logic         play_done = 1'b0;
    logic         play_abort;
    logic [N-1:0] pending;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    snd_trigger_arbiter #(
        .N_REQ        (N),
        .DEBOUNCE_CYC (D),
        .GAP_CYC      (G)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_raw    (btn_raw),
        .play_valid (play_valid),
        .play_id    (play_id),
        .play_ready (play_ready),
        .play_done  (play_done),
        .play_abort (play_abort),
        .pending    (pending),
        .busy       (busy)
    );

    // ---------------- helpers (stimulus/timing only) ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        btn_raw    = '0;
        play_ready = 1'b0;
        play_done  = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!play_valid && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    // Drive a one-cycle done pulse, then count cycles until play_valid.
    task automatic pulse_done_wait(input int limit, output int n);
        play_done = 1'b1;
        tick(1);
        play_done = 1'b0;
        n = 1;
        while (!play_valid && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    task automatic handshake();
        play_ready = 1'b1;
        tick(1);
        play_ready = 1'b0;
    endtask

    // Reference round-robin: first requested id after 'last', wrapping.
    function automatic int model_next(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        tick(1);
        n_tests++;
        if ({play_valid, busy, play_abort} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000", {play_valid, busy, play_abort});
        end
        n_tests++;
        if (pending !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_pending: got %h want 00", pending);
        end
        n_tests++;
        if (play_id !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_id: got %0d want 0", play_id);
        end
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_single_press();
        int n;
        do_reset();
        btn_raw = 8'h08;
        n = 0;
        while (pending == 8'h00 && n < D + 10) begin
            tick(1);
            n++;
        end
        n_tests++;
        if (n !== D + 3 || pending !== 8'h08) begin
            n_fail++;
            $display("FAIL press_latency: got %0d cycles pending=%h want %0d cycles pending=08", n, pending, D + 3);
        end
        tick(1);
        n_tests++;
        if (play_valid !== 1'b1 || play_id !== 3'd3) begin
            n_fail++;
            $display("FAIL press_issue: got valid=%b id=%0d want valid=1 id=3", play_valid, play_id);
        end
        handshake();
        n_tests++;
        if (pending !== 8'h00 || play_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL press_accept: got pending=%h valid=%b busy=%b want 00 0 1", pending, play_valid, busy);
        end
        btn_raw = 8'h00;
        tick(D + 5);
        n_tests++;
        if (pending !== 8'h00) begin
            n_fail++;
            $display("FAIL release_no_effect: got pending=%h want 00", pending);
        end
        pulse_done_wait(G + 5, n);
        n_tests++;
        if (play_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL press_idle: got valid=%b busy=%b want 0 0", play_valid, busy);
        end
    endtask

    task automatic test_glitch();
        bit seen;
        do_reset();
        btn_raw = 8'h20;
        seen = 0;
        for (int i = 0; i < D - 1; i++) begin
            tick(1);
            if (pending != 8'h00 || play_valid) seen = 1;
        end
        btn_raw = 8'h00;
        for (int i = 0; i < 3 * D; i++) begin
            tick(1);
            if (pending != 8'h00 || play_valid) seen = 1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch: got a request/issue for a %0d-cycle pulse want none", D - 1);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] mask;
        int last, exp, n;
        do_reset();
        play_ready = 1'b1;
        btn_raw = 8'h85;
        mask = 8'h85;
        last = N - 1;
        wait_valid(D + 10, n);
        for (int k = 0; k < 3; k++) begin
            exp = model_next(mask, last);
            n_tests++;
            if (play_valid !== 1'b1 || int'(play_id) !== exp) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got valid=%b id=%0d want id=%0d", k, play_valid, play_id, exp);
            end
            tick(1);
            mask[exp] = 1'b0;
            last = exp;
            n_tests++;
            if (pending !== mask) begin
                n_fail++;
                $display("FAIL rr_pending[%0d]: got %h want %h", k, pending, mask);
            end
            tick(99);
            pulse_done_wait(G + 5, n);
            n_tests++;
            if (mask != 0 && n !== G + 2) begin
                n_fail++;
                $display("FAIL rr_gap[%0d]: got %0d cycles want %0d", k, n, G + 2);
            end else if (mask == 0 && (play_valid !== 1'b0 || busy !== 1'b0)) begin
                n_fail++;
                $display("FAIL rr_end: got valid=%b busy=%b want 0 0", play_valid, busy);
            end
        end
        play_ready = 1'b0;
        btn_raw = 8'h00;
        tick(D + 5);
    endtask

`ifndef SNDARB_PREEMPT_EN
    task automatic test_coalesce();
        int n;
        do_reset();
        btn_raw = 8'h04;
        wait_valid(D + 10, n);
        handshake();
        btn_raw = 8'h00;
        tick(D + 5);
        btn_raw = 8'h04;
        tick(D + 5);
        btn_raw = 8'h00;
        tick(D + 5);
        btn_raw = 8'h04;
        tick(D + 5);
        n_tests++;
        if (pending !== 8'h04 || play_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL coalesce_pending: got pending=%h valid=%b busy=%b want 04 0 1", pending, play_valid, busy);
        end
        pulse_done_wait(G + 5, n);
        n_tests++;
        if (n !== G + 2 || play_id !== 3'd2) begin
            n_fail++;
            $display("FAIL coalesce_reissue: got %0d cycles id=%0d want %0d cycles id=2", n, play_id, G + 2);
        end
        handshake();
        n_tests++;
        if (pending !== 8'h00) begin
            n_fail++;
            $display("FAIL coalesce_single: got pending=%h want 00", pending);
        end
        btn_raw = 8'h00;
        play_done = 1'b1;
        tick(1);
        play_done = 1'b0;
        tick(G + D + 10);
    endtask
`endif

    task automatic test_same_cycle();
        int n;
        do_reset();
        btn_raw = 8'h10;
        wait_valid(D + 10, n);
        btn_raw = 8'h00;
        tick(D + 5);
        btn_raw = 8'h10;
        // The new edge latches D+3 cycles after the press: align the handshake to it.
        tick(D + 2);
        play_ready = 1'b1;
        tick(1);
        play_ready = 1'b0;
        n_tests++;
        if (pending !== 8'h10 || play_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_set: got pending=%h valid=%b busy=%b want 10 0 1", pending, play_valid, busy);
        end
        pulse_done_wait(G + 5, n);
        n_tests++;
        if (n !== G + 2 || play_id !== 3'd4) begin
            n_fail++;
            $display("FAIL same_cycle_reissue: got %0d cycles id=%0d want %0d cycles id=4", n, play_id, G + 2);
        end
        btn_raw = 8'h00;
    endtask

    task automatic test_reset_in_issue();
        int n;
        do_reset();
        btn_raw = 8'h42;
        wait_valid(D + 10, n);
        n_tests++;
        if (play_valid !== 1'b1 || play_id !== 3'd1) begin
            n_fail++;
            $display("FAIL rst_pre_issue: got valid=%b id=%0d want 1 1", play_valid, play_id);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (play_valid !== 1'b0 || busy !== 1'b0 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_async: got valid=%b busy=%b pending=%h want 0 0 00", play_valid, busy, pending);
        end
        tick(2);
        reset_n = 1'b1;
        // Buttons are still held, so both re-debounce after reset.
        wait_valid(D + 10, n);
        n_tests++;
        if (play_valid !== 1'b1 || play_id !== 3'd1 || pending !== 8'h42) begin
            n_fail++;
            $display("FAIL rst_first_grant: got valid=%b id=%0d pending=%h want 1 1 42", play_valid, play_id, pending);
        end
        btn_raw = 8'h00;
    endtask

`ifdef SNDARB_PREEMPT_EN
    task automatic test_preempt();
        int n, aborts;
        do_reset();
        btn_raw = 8'h02;
        wait_valid(D + 10, n);
        handshake();
        btn_raw = 8'h22;
        n = 0;
        while (!play_abort && n < D + 10) begin
            tick(1);
            n++;
        end
        n_tests++;
        if (n !== D + 3 || pending !== 8'h20) begin
            n_fail++;
            $display("FAIL preempt_abort: got %0d cycles pending=%h want %0d cycles pending=20", n, pending, D + 3);
        end
        aborts = 0;
        for (int i = 0; i < G + 4; i++) begin
            tick(1);
            if (play_abort) aborts++;
        end
        n_tests++;
        if (aborts !== 0 || play_valid !== 1'b1 || play_id !== 3'd5) begin
            n_fail++;
            $display("FAIL preempt_gap: got extra=%0d valid=%b id=%0d want 0 1 5", aborts, play_valid, play_id);
        end
        btn_raw = 8'h00;
    endtask
`endif

    task automatic test_random();
        logic [N-1:0] mask;
        int last, exp, n, dly;
        do_reset();
        last = N - 1;
        for (int it = 0; it < 6; it++) begin
            mask = N'($urandom_range(1, 255));
            btn_raw = mask;
            wait_valid(D + 10, n);
            while (mask != 0) begin
                exp = model_next(mask, last);
                dly = $urandom_range(0, 4);
                tick(dly);
                n_tests++;
                if (play_valid !== 1'b1 || int'(play_id) !== exp || play_abort !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_issue[%0d]: got valid=%b id=%0d abort=%b want 1 %0d 0", it, play_valid, play_id, play_abort, exp);
                end
                handshake();
                mask[exp] = 1'b0;
                last = exp;
                n_tests++;
                if (pending !== mask) begin
                    n_fail++;
                    $display("FAIL rand_pending[%0d]: got %h want %h", it, pending, mask);
                end
                tick($urandom_range(1, 30));
                pulse_done_wait(G + 5, n);
                if (mask != 0) begin
                    n_tests++;
                    if (n !== G + 2) begin
                        n_fail++;
                        $display("FAIL rand_gap[%0d]: got %0d cycles want %0d", it, n, G + 2);
                    end
                end
            end
            n_tests++;
            if (busy !== 1'b0 || play_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_idle[%0d]: got busy=%b valid=%b want 0 0", it, busy, play_valid);
            end
            btn_raw = 8'h00;
            tick(D + 5);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_round_robin();
`ifndef SNDARB_PREEMPT_EN
        test_coalesce();
`endif
        test_same_cycle();
        test_reset_in_issue();
`ifdef SNDARB_PREEMPT_EN
        test_preempt();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
